// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// synth_pkg : shared mode encodings and width helper for the key recorder
// Revision  : 1.0
// ============================================================================
package synth_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_REC  = 2'b01;
    localparam logic [1:0] MODE_PLAY = 2'b10;
    localparam logic [1:0] MODE_OVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REC  = 2'b01,
        ST_PLAY = 2'b10,
        ST_OVD  = 2'b11
    } mode_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rec_tick_gen.sv
`default_nettype none
// ============================================================================
// rec_tick_gen : TICK_DIV-cycle step timer with enable and synchronous clear
// Revision     : 1.0
// ============================================================================
module rec_tick_gen
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (clog2(TICK_DIV) > 1) ? clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multitrack_recorder.sv
`default_nettype none
// ============================================================================
// multitrack_recorder : tick-rate key capture into NUM_TRACKS loop tracks with
//                       record / overdub / play / clear and muted OR replay
// Revision            : 1.0
// ============================================================================
module multitrack_recorder
    import synth_pkg::*;
#(
    parameter  int NUM_KEYS   = 4,
    parameter  int NUM_TRACKS = 2,
    parameter  int DEPTH      = 256,
    parameter  int TICK_DIV   = 500000,
    localparam int ADDR_W     = clog2(DEPTH),
    localparam int TRK_W      = (clog2(NUM_TRACKS) > 1) ? clog2(NUM_TRACKS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic [1:0]            cmd,
    input  logic [TRK_W-1:0]      track,
    input  logic [NUM_TRACKS-1:0] mute,
    input  logic [NUM_KEYS-1:0]   keys,
    output logic [1:0]            mode,
    output logic [NUM_KEYS-1:0]   playback_keys,
    output logic [ADDR_W-1:0]     step,
    output logic [ADDR_W:0]       loop_len,
    output logic                  full
);

    localparam int WORD_W = NUM_TRACKS * NUM_KEYS;
    localparam logic [ADDR_W-1:0] c_STEP_LAST = ADDR_W'(DEPTH - 1);

    mode_t                 r_mode, w_mode_nxt;
    logic [ADDR_W-1:0]     r_step, w_step_nxt;
    logic [ADDR_W:0]       r_loop_len, w_loop_len_nxt;
    logic                  r_full, w_full_nxt;
    logic                  r_first, w_first_nxt;
    logic [TRK_W-1:0]      r_track, w_track_nxt;
    logic [NUM_TRACKS-1:0] r_mute;
    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic [WORD_W-1:0]     r_rd_word, w_wr_word;
    logic                  w_wr_en, w_tick, w_accept, w_trk_ok, w_have_loop, w_step_wrap, w_tick_en;

    assign w_trk_ok    = int'(track) < NUM_TRACKS;
    assign w_have_loop = (r_loop_len != '0);
    assign w_step_wrap = ({1'b0, r_step} == (r_loop_len - 1'b1));
    assign w_tick_en   = (r_mode != ST_IDLE);

    rec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clock),
        .rst      (reset),
        .i_enable (w_tick_en),
        .i_clear  (w_accept),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_mode_nxt     = r_mode;
        w_step_nxt     = r_step;
        w_loop_len_nxt = r_loop_len;
        w_full_nxt     = r_full;
        w_first_nxt    = r_first;
        w_track_nxt    = r_track;
        w_accept       = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_word      = r_rd_word;

        if (go) begin
            case (cmd)
                MODE_IDLE: begin
                    w_accept   = 1'b1;
                    w_mode_nxt = ST_IDLE;
                    if (r_mode == ST_IDLE) begin
                        w_loop_len_nxt = '0;
                        w_full_nxt     = 1'b0;
                    end
                end
                MODE_REC: begin
                    if (w_trk_ok) begin
                        w_accept    = 1'b1;
                        w_mode_nxt  = ST_REC;
                        w_track_nxt = track;
                        w_first_nxt = !w_have_loop;
                    end
                end
                MODE_OVD: begin
                    if (w_trk_ok && w_have_loop) begin
                        w_accept    = 1'b1;
                        w_mode_nxt  = ST_OVD;
                        w_track_nxt = track;
                        w_first_nxt = 1'b0;
                    end
                end
                default: begin
                    if (w_have_loop) begin
                        w_accept   = 1'b1;
                        w_mode_nxt = ST_PLAY;
                    end
                end
            endcase
            if (w_accept) w_step_nxt = '0;
        end

        // An accepted command discards the coincident tick entirely
        if (!w_accept && w_tick) begin
            case (r_mode)
                ST_REC, ST_OVD: begin
                    w_wr_en = 1'b1;
                    for (int t = 0; t < NUM_TRACKS; t++) begin
                        if (TRK_W'(t) == r_track) begin
                            w_wr_word[t*NUM_KEYS +: NUM_KEYS] = (r_mode == ST_OVD) ?
                                (r_rd_word[t*NUM_KEYS +: NUM_KEYS] | keys) : keys;
                        end else if (r_first) begin
                            w_wr_word[t*NUM_KEYS +: NUM_KEYS] = '0;
                        end
                    end
                    if (r_first) begin
                        w_loop_len_nxt = {1'b0, r_step} + 1'b1;
                        if (r_step == c_STEP_LAST) begin
                            w_full_nxt = 1'b1;
                            w_mode_nxt = ST_IDLE;
                        end else begin
                            w_step_nxt = r_step + 1'b1;
                        end
                    end else begin
                        w_step_nxt = w_step_wrap ? '0 : r_step + 1'b1;
                    end
                end
                ST_PLAY: w_step_nxt = w_step_wrap ? '0 : r_step + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode     <= ST_IDLE;
            r_step     <= '0;
            r_loop_len <= '0;
            r_full     <= 1'b0;
            r_first    <= 1'b0;
            r_track    <= '0;
            r_mute     <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_step     <= w_step_nxt;
            r_loop_len <= w_loop_len_nxt;
            r_full     <= w_full_nxt;
            r_first    <= w_first_nxt;
            r_track    <= w_track_nxt;
            r_mute     <= mute;
        end
    end

    // Read and write share the step address, so a write bypasses to the read port
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_step] <= w_wr_word;
            r_rd_word     <= w_wr_word;
        end else begin
            r_rd_word     <= r_mem[r_step];
        end
    end

    always_comb begin
        playback_keys = '0;
        if (r_mode != ST_IDLE) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (!r_mute[t] && !((r_mode == ST_REC || r_mode == ST_OVD) && TRK_W'(t) == r_track)) begin
                    playback_keys = playback_keys | r_rd_word[t*NUM_KEYS +: NUM_KEYS];
                end
            end
        end
    end

    assign mode     = r_mode;
    assign step     = r_step;
    assign loop_len = r_loop_len;
    assign full     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_multitrack_recorder.sv
`default_nettype none
// ============================================================================
// tb_multitrack_recorder : randomized scenarios against a per-track loop model
// Revision               : 1.0
// ============================================================================
module tb_multitrack_recorder;

    localparam int NK = 4;
    localparam int NT = 2;
    localparam int DP = 8;
    localparam int TD = 4;
    localparam logic [1:0] C_STOP = 2'b00;
    localparam logic [1:0] C_REC  = 2'b01;
    localparam logic [1:0] C_PLAY = 2'b10;
    localparam logic [1:0] C_OVD  = 2'b11;

    logic          clock = 1'b0;
    logic          reset, go, track;
    logic [1:0]    cmd, mute, mode;
    logic [NK-1:0] keys, playback_keys;
    logic [2:0]    step;
    logic [3:0]    loop_len;
    logic          full;

    int n_cmp = 0;
    int n_err = 0;

    logic [NK-1:0] m_trk [NT][DP];
    int            m_len;
    logic [NK-1:0] g_vals [16];

    multitrack_recorder #(
        .NUM_KEYS   (NK),
        .NUM_TRACKS (NT),
        .DEPTH      (DP),
        .TICK_DIV   (TD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .go            (go),
        .cmd           (cmd),
        .track         (track),
        .mute          (mute),
        .keys          (keys),
        .mode          (mode),
        .playback_keys (playback_keys),
        .step          (step),
        .loop_len      (loop_len),
        .full          (full)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] c, input int t);
        cmd   = c;
        track = 1'(t);
        go    = 1'b1;
        cyc(1);
        go    = 1'b0;
    endtask

    function automatic logic [NK-1:0] pb_model(input int s, input logic [1:0] mu, input bit excl, input int et);
        logic [NK-1:0] r;
        r = '0;
        for (int t = 0; t < NT; t++) begin
            if (!mu[t] && !(excl && t == et)) r = r | m_trk[t][s];
        end
        return r;
    endfunction

    // Entered one cycle after an accepted PLAY; samples the middle of every step
    task automatic check_play(input int nsteps, input bit randmute);
        logic [NK-1:0] exp_pb;
        for (int k = 0; k < nsteps; k++) begin
            cyc(1);
            if (randmute) mute = 2'($urandom_range(0, 3));
            cyc(1);
            exp_pb = pb_model(k % m_len, mute, 1'b0, 0);
            n_cmp++;
            if (playback_keys !== exp_pb) begin
                n_err++;
                $display("FAIL play_keys step%0d: got %b expected %b (mute %b)", k, playback_keys, exp_pb, mute);
            end
            n_cmp++;
            if (step !== 3'(k % m_len)) begin
                n_err++;
                $display("FAIL play_step k%0d: got %0d expected %0d", k, step, k % m_len);
            end
            cyc(2);
        end
    endtask

    task automatic rec_first(input int t, input int len);
        do_cmd(C_REC, t);
        for (int s = 0; s < len; s++) begin
            keys = g_vals[s];
            cyc(TD);
            m_trk[t][s]     = g_vals[s];
            m_trk[1 - t][s] = '0;
        end
        keys  = '0;
        m_len = len;
    endtask

    task automatic rec_more(input int t, input int n, input bit ovd);
        logic [NK-1:0] exp_pb;
        int s;
        do_cmd(ovd ? C_OVD : C_REC, t);
        for (int k = 0; k < n; k++) begin
            s    = k % m_len;
            keys = g_vals[k];
            cyc(1);
            mute = 2'($urandom_range(0, 3));
            cyc(1);
            exp_pb = pb_model(s, mute, 1'b1, t);
            n_cmp++;
            if (playback_keys !== exp_pb) begin
                n_err++;
                $display("FAIL monitor_keys k%0d: got %b expected %b (track %0d mute %b)", k, playback_keys, exp_pb, t, mute);
            end
            n_cmp++;
            if (step !== 3'(s)) begin
                n_err++;
                $display("FAIL rec_step k%0d: got %0d expected %0d", k, step, s);
            end
            cyc(2);
            m_trk[t][s] = ovd ? (m_trk[t][s] | g_vals[k]) : g_vals[k];
        end
        keys = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; cmd = '0; track = 1'b0; mute = '0; keys = '0;
        cyc(3);
        n_cmp++;
        if ({mode, step, loop_len, full, playback_keys} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got mode %b step %0d len %0d full %b pb %b expected all zero",
                     mode, step, loop_len, full, playback_keys);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_play_empty();
        do_cmd(C_PLAY, 0);
        cyc(2);
        n_cmp++;
        if (mode !== 2'b00 || playback_keys !== '0) begin
            n_err++;
            $display("FAIL play_empty: got mode %b pb %b expected 00 0000", mode, playback_keys);
        end
        do_cmd(C_OVD, 1);
        cyc(1);
        n_cmp++;
        if (mode !== 2'b00) begin
            n_err++;
            $display("FAIL ovd_empty: got mode %b expected 00", mode);
        end
    endtask

    task automatic test_first_record();
        g_vals[0] = 4'b0001; g_vals[1] = 4'b0010; g_vals[2] = 4'b0100;
        rec_first(0, 3);
        n_cmp++;
        if (mode !== C_REC || loop_len !== 4'd3) begin
            n_err++;
            $display("FAIL first_rec: got mode %b len %0d expected 01 3", mode, loop_len);
        end
        do_cmd(C_STOP, 0);
        n_cmp++;
        if (mode !== 2'b00 || playback_keys !== '0 || loop_len !== 4'd3) begin
            n_err++;
            $display("FAIL stop: got mode %b pb %b len %0d expected 00 0000 3", mode, playback_keys, loop_len);
        end
        mute = '0;
        do_cmd(C_PLAY, 0);
        n_cmp++;
        if (mode !== C_PLAY) begin
            n_err++;
            $display("FAIL play_mode: got %b expected 10", mode);
        end
        check_play(7, 1'b0);
    endtask

    task automatic test_second_track();
        for (int i = 0; i < 16; i++) g_vals[i] = 4'b1000;
        rec_more(1, 3, 1'b0);
        do_cmd(C_STOP, 0);
        mute = '0;
        do_cmd(C_PLAY, 0);
        check_play(6, 1'b0);
    endtask

    task automatic test_mute_overdub();
        do_cmd(C_PLAY, 0);
        check_play(4, 1'b1);
        g_vals[0] = 4'b0001;
        rec_more(1, 1, 1'b1);
        do_cmd(C_STOP, 0);
        mute = '0;
        do_cmd(C_PLAY, 0);
        check_play(3, 1'b0);
    endtask

    task automatic test_go_on_tick();
        do_cmd(C_PLAY, 0);
        cyc(2 * TD - 1);
        do_cmd(C_PLAY, 0);
        n_cmp++;
        if (step !== 3'd0 || mode !== C_PLAY) begin
            n_err++;
            $display("FAIL go_on_tick: got step %0d mode %b expected 0 10", step, mode);
        end
        check_play(3, 1'b1);
    endtask

    task automatic test_random_loops();
        int len, t;
        for (int it = 0; it < 4; it++) begin
            do_cmd(C_STOP, 0);
            do_cmd(C_STOP, 0);
            n_cmp++;
            if (loop_len !== 4'd0) begin
                n_err++;
                $display("FAIL clear_it%0d: got len %0d expected 0", it, loop_len);
            end
            len = int'($urandom_range(1, DP - 1));
            t   = int'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) g_vals[i] = 4'($urandom);
            rec_first(t, len);
            n_cmp++;
            if (loop_len !== 4'(len)) begin
                n_err++;
                $display("FAIL rand_len_it%0d: got %0d expected %0d", it, loop_len, len);
            end
            for (int i = 0; i < 16; i++) g_vals[i] = 4'($urandom);
            rec_more(1 - t, int'($urandom_range(1, 2 * len)), 1'b0);
            for (int i = 0; i < 16; i++) g_vals[i] = 4'($urandom);
            rec_more(int'($urandom_range(0, 1)), int'($urandom_range(1, len + 1)), 1'b1);
            do_cmd(C_PLAY, 0);
            check_play(len + 2, 1'b1);
        end
    endtask

    task automatic test_full();
        int t;
        do_cmd(C_STOP, 0);
        do_cmd(C_STOP, 0);
        t = int'($urandom_range(0, 1));
        for (int i = 0; i < DP; i++) g_vals[i] = 4'($urandom);
        do_cmd(C_REC, t);
        for (int s = 0; s < DP; s++) begin
            keys = g_vals[s];
            if (s == DP - 1) begin
                cyc(TD - 1);
                n_cmp++;
                if (mode !== C_REC || full !== 1'b0) begin
                    n_err++;
                    $display("FAIL pre_full: got mode %b full %b expected 01 0", mode, full);
                end
                cyc(1);
            end else begin
                cyc(TD);
            end
            m_trk[t][s]     = g_vals[s];
            m_trk[1 - t][s] = '0;
        end
        keys  = '0;
        m_len = DP;
        n_cmp++;
        if (mode !== 2'b00 || full !== 1'b1 || loop_len !== 4'd8) begin
            n_err++;
            $display("FAIL full: got mode %b full %b len %0d expected 00 1 8", mode, full, loop_len);
        end
        do_cmd(C_PLAY, 0);
        check_play(10, 1'b1);
        do_cmd(C_STOP, 0);
        do_cmd(C_STOP, 0);
        n_cmp++;
        if (loop_len !== 4'd0 || full !== 1'b0 || mode !== 2'b00) begin
            n_err++;
            $display("FAIL clear_full: got len %0d full %b mode %b expected 0 0 00", loop_len, full, mode);
        end
        do_cmd(C_PLAY, 0);
        cyc(1);
        n_cmp++;
        if (mode !== 2'b00) begin
            n_err++;
            $display("FAIL play_after_clear: got mode %b expected 00", mode);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) g_vals[i] = 4'($urandom) | 4'b0001;
        rec_first(0, 2);
        mute = '0;
        do_cmd(C_PLAY, 0);
        cyc(5);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({mode, step, loop_len, full, playback_keys} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got mode %b step %0d len %0d full %b pb %b expected all zero",
                     mode, step, loop_len, full, playback_keys);
        end
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_play_empty();
        test_first_record();
        test_second_track();
        test_mute_overdub();
        test_go_on_tick();
        test_random_loops();
        test_full();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
